flags_unit: RTL and testbench

- Architectural FLAGS register for the 8088 core, directly downstream of the ALU.
- Captures the ALU status outputs (OF/SF/ZF/AF/PF/CF) under a per-operation update mask.
- Executes the flag-control instructions CLC/STC/CMC/CLI/STI/CLD/STD, POPF/IRET word loads and SAHF byte loads.
- Tracks the STI/SS interrupt shadow and the TF single-step trap, and returns CF to the ALU carryIn.

---
 rtl/flags_pkg.sv | 32 +++
 rtl/flags_if.sv | 31 +++
 rtl/flags_alu_mask.sv | 18 +
 rtl/flags_unit.sv | 110 +++++++++++
 tb/tb_flags_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/flags_pkg.sv
// Shared definitions for the 8088 FLAGS register: bit positions, flag-control
// encodings, constant-bit masks and the ALU operation codes that drive flag capture.
package flags_pkg;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [15:0] RESET_FLAGS   = 16'hF002;
  // Bits 15:12 and 1 always read 1; bits 5 and 3 always read 0.
  localparam logic [15:0] FLAGS_OR_MASK = 16'hF002;
  localparam logic [15:0] FLAGS_WR_MASK = 16'h0FD5;
  localparam logic [15:0] SAHF_MASK     = 16'h00D5;
  localparam logic [15:0] STATUS_MASK   = 16'h08D5;

  typedef enum logic [2:0] {
    FC_NOP = 3'd0, FC_CLC = 3'd1, FC_STC = 3'd2, FC_CMC = 3'd3,
    FC_CLI = 3'd4, FC_STI = 3'd5, FC_CLD = 3'd6, FC_STD = 3'd7
  } flagctl_e;

  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_NOTA  = 4'b0001;
  localparam logic [3:0] ALU_INCA  = 4'b0010;
  localparam logic [3:0] ALU_DECA  = 4'b0011;

endpackage

// File: rtl/flags_if.sv
// Command/status bundle between the execution unit and the FLAGS register.
interface flags_if;
  import flags_pkg::*;

  logic        AluUpdate;
  logic [3:0]  AluOperation;
  logic        F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry;
  flagctl_e    FlagCtl;
  logic        LoadWord;
  logic        LoadLow;
  logic [15:0] LoadData;
  logic        ShadowReq;
  logic        IntEntry;
  logic        InstrEnd;
  logic [15:0] Flags;
  logic        CarryOut;
  logic        IntEnable;
  logic        TrapPending;

  modport master (
    output AluUpdate, AluOperation, F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry,
           FlagCtl, LoadWord, LoadLow, LoadData, ShadowReq, IntEntry, InstrEnd,
    input  Flags, CarryOut, IntEnable, TrapPending
  );

  modport slave (
    input  AluUpdate, AluOperation, F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry,
           FlagCtl, LoadWord, LoadLow, LoadData, ShadowReq, IntEntry, InstrEnd,
    output Flags, CarryOut, IntEnable, TrapPending
  );
endinterface

// File: rtl/flags_alu_mask.sv
// Decodes an ALU operation code into the set of FLAGS bits that operation writes.
module flags_alu_mask
  import flags_pkg::*;
(
  input  logic [3:0]  op_i,
  output logic [15:0] mask_o
);

  always_comb begin
    mask_o = '0;
    casez (op_i)
      4'b1???:           mask_o = STATUS_MASK;
      ALU_INCA, ALU_DECA: mask_o = STATUS_MASK & ~(16'h1 << FLAG_CF);
      default:           mask_o = '0;
    endcase
  end

endmodule

// File: rtl/flags_unit.sv
// Architectural FLAGS register: prioritised write sources, STI/SS interrupt
// shadow and TF single-step trap tracking.
module flags_unit #(
  parameter logic [15:0] RESET_FLAGS = flags_pkg::RESET_FLAGS
) (
  input logic    CLK,
  input logic    RESET_n,
  flags_if.slave bus
);
  import flags_pkg::*;

  logic [15:0] flags_q, flags_d;
  logic        shadow_q, shadow_d;
  logic        shcnt_q, shcnt_d;
  logic        tfarm_q, tfarm_d;
  logic        trap_q, trap_d;
  logic        sti_set;
  logic [15:0] alu_mask, alu_v;

  flags_alu_mask u_mask (.op_i(bus.AluOperation), .mask_o(alu_mask));

  always_comb begin
    alu_v          = '0;
    alu_v[FLAG_OF] = bus.F_Overflow;
    alu_v[FLAG_SF] = bus.F_Neg;
    alu_v[FLAG_ZF] = bus.F_Zero;
    alu_v[FLAG_AF] = bus.F_Aux;
    alu_v[FLAG_PF] = bus.F_Parity;
    alu_v[FLAG_CF] = bus.F_Carry;
  end

  // One write source per cycle, highest priority first.
  always_comb begin
    flags_d = flags_q;
    sti_set = 1'b0;
    if (bus.IntEntry) begin
      flags_d[FLAG_IF] = 1'b0;
      flags_d[FLAG_TF] = 1'b0;
    end else if (bus.LoadWord) begin
      flags_d = bus.LoadData;
    end else if (bus.LoadLow) begin
      flags_d = (flags_q & ~SAHF_MASK) | (bus.LoadData & SAHF_MASK);
    end else if (bus.FlagCtl != FC_NOP) begin
      case (bus.FlagCtl)
        FC_CLC: flags_d[FLAG_CF] = 1'b0;
        FC_STC: flags_d[FLAG_CF] = 1'b1;
        FC_CMC: flags_d[FLAG_CF] = ~flags_q[FLAG_CF];
        FC_CLI: flags_d[FLAG_IF] = 1'b0;
        FC_STI: begin
          flags_d[FLAG_IF] = 1'b1;
          sti_set          = ~flags_q[FLAG_IF];
        end
        FC_CLD: flags_d[FLAG_DF] = 1'b0;
        FC_STD: flags_d[FLAG_DF] = 1'b1;
        default: ;
      endcase
    end else if (bus.AluUpdate) begin
      flags_d = (flags_q & ~alu_mask) | (alu_v & alu_mask);
    end
    flags_d = (flags_d & FLAGS_WR_MASK) | FLAGS_OR_MASK;
  end

  // Boundary logic looks at flags_q, i.e. TF/IF before any same-cycle write.
  always_comb begin
    shadow_d = shadow_q;
    shcnt_d  = shcnt_q;
    tfarm_d  = tfarm_q;
    trap_d   = trap_q;
    if (bus.IntEntry) begin
      shadow_d = 1'b0;
      shcnt_d  = 1'b0;
      tfarm_d  = 1'b0;
      trap_d   = 1'b0;
    end else begin
      if (bus.InstrEnd) begin
        tfarm_d = flags_q[FLAG_TF];
        trap_d  = trap_q | (tfarm_q & flags_q[FLAG_TF]);
      end
      if (sti_set || bus.ShadowReq) begin
        shadow_d = 1'b1;
        shcnt_d  = 1'b0;
      end else if (bus.InstrEnd && shadow_q) begin
        shadow_d = ~shcnt_q;
        shcnt_d  = ~shcnt_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      flags_q  <= RESET_FLAGS;
      shadow_q <= 1'b0;
      shcnt_q  <= 1'b0;
      tfarm_q  <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      shcnt_q  <= shcnt_d;
      tfarm_q  <= tfarm_d;
      trap_q   <= trap_d;
    end
  end

  assign bus.Flags       = flags_q;
  assign bus.CarryOut    = flags_q[FLAG_CF];
  assign bus.IntEnable   = flags_q[FLAG_IF] & ~shadow_q;
  assign bus.TrapPending = trap_q;

endmodule

// File: tb/tb_flags_unit.sv
// Directed scoreboard bench for flags_unit: each command pushes its expected
// post-edge state; a negedge monitor pops and compares.
module tb_flags_unit;
  import flags_pkg::*;

  typedef struct {
    string       nm;
    logic [15:0] fl;
    logic        ie;
    logic        tp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  flags_if bus ();

  flags_unit dut (.CLK(clk), .RESET_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (bus.Flags !== e.fl || bus.CarryOut !== e.fl[0] ||
          bus.IntEnable !== e.ie || bus.TrapPending !== e.tp) begin
        bad++;
        $display("FAIL %s: got Flags=%h CF=%b IE=%b TP=%b want Flags=%h CF=%b IE=%b TP=%b",
                 e.nm, bus.Flags, bus.CarryOut, bus.IntEnable, bus.TrapPending,
                 e.fl, e.fl[0], e.ie, e.tp);
      end
    end
  end

  task automatic idle();
    bus.AluUpdate    = 1'b0;
    bus.AluOperation = 4'b0000;
    bus.F_Overflow   = 1'b0;
    bus.F_Neg        = 1'b0;
    bus.F_Zero       = 1'b0;
    bus.F_Aux        = 1'b0;
    bus.F_Parity     = 1'b0;
    bus.F_Carry      = 1'b0;
    bus.FlagCtl      = FC_NOP;
    bus.LoadWord     = 1'b0;
    bus.LoadLow      = 1'b0;
    bus.LoadData     = 16'h0000;
    bus.ShadowReq    = 1'b0;
    bus.IntEntry     = 1'b0;
    bus.InstrEnd     = 1'b0;
  endtask

  // Apply the currently driven command for one edge, then queue its expected result.
  task automatic step(input string nm, input logic [15:0] fl, input logic ie, input logic tp);
    @(posedge clk);
    #1;
    idle();
    sb.push_back('{nm, fl, ie, tp});
  endtask

  task automatic alu(input logic [3:0] op, input logic [5:0] ofszapc);
    bus.AluUpdate    = 1'b1;
    bus.AluOperation = op;
    {bus.F_Overflow, bus.F_Neg, bus.F_Zero, bus.F_Aux, bus.F_Parity, bus.F_Carry} = ofszapc;
  endtask

  task automatic popf(input logic [15:0] d);
    bus.LoadWord = 1'b1;
    bus.LoadData = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset wins over an in-flight load.
    popf(16'hFFFF); step("reset1", 16'hF002, 1'b0, 1'b0);
    popf(16'hFFFF); step("reset2", 16'hF002, 1'b0, 1'b0);
    rst_n = 1'b1;

    bus.FlagCtl = FC_STC;            step("stc",        16'hF003, 1'b0, 1'b0);
    alu(ALU_INCA, 6'b101000);        step("inc_keepcf", 16'hF843, 1'b0, 1'b0);
    alu(4'b1000,  6'b101000);        step("add_cf",     16'hF842, 1'b0, 1'b0);
    alu(ALU_PASSA, 6'b111111);       step("pass_none",  16'hF842, 1'b0, 1'b0);

    bus.FlagCtl = FC_STC;
    alu(4'b1000, 6'b000000);
    bus.LoadLow = 1'b1; bus.LoadData = 16'h00D5;
                                     step("prio_sahf",  16'hF8D7, 1'b0, 1'b0);
    bus.FlagCtl = FC_CMC;            step("cmc",        16'hF8D6, 1'b0, 1'b0);
    popf(16'h0000);                  step("popf_0000",  16'hF002, 1'b0, 1'b0);
    popf(16'h0FFF);                  step("popf_0fff",  16'hFFD7, 1'b1, 1'b0);
    popf(16'h0000);                  step("popf_clr",   16'hF002, 1'b0, 1'b0);

    // STI from IF=0 shadows interrupts until the end of the next instruction.
    bus.FlagCtl = FC_STI;            step("sti_shadow", 16'hF202, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("sti_ie1",    16'hF202, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("sti_ie2",    16'hF202, 1'b1, 1'b0);
    bus.ShadowReq = 1'b1;            step("ss_shadow",  16'hF202, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("ss_ie1",     16'hF202, 1'b0, 1'b0);
    bus.ShadowReq = 1'b1;            step("ss_restart", 16'hF202, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("ss_rst_ie1", 16'hF202, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("ss_rst_ie2", 16'hF202, 1'b1, 1'b0);
    bus.FlagCtl = FC_STI;            step("sti_if1",    16'hF202, 1'b1, 1'b0);
    bus.FlagCtl = FC_STD;            step("std",        16'hF602, 1'b1, 1'b0);
    bus.FlagCtl = FC_CLD;            step("cld",        16'hF202, 1'b1, 1'b0);
    bus.FlagCtl = FC_CLI;            step("cli",        16'hF002, 1'b0, 1'b0);

    // Single-step: TF from POPF traps after the following instruction.
    popf(16'h0100);                  step("popf_tf",    16'hF102, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("tf_ie1",     16'hF102, 1'b0, 1'b0);
    bus.InstrEnd = 1'b1;             step("tf_ie2",     16'hF102, 1'b0, 1'b1);
                                     step("tf_hold",    16'hF102, 1'b0, 1'b1);
    bus.IntEntry = 1'b1;             step("intentry",   16'hF002, 1'b0, 1'b0);

    // Boundary in the same cycle as a TF-setting write sees the old TF.
    popf(16'h0300); bus.InstrEnd = 1'b1;
                                     step("popf_ie",    16'hF302, 1'b1, 1'b0);
    bus.InstrEnd = 1'b1;             step("pie_ie1",    16'hF302, 1'b1, 1'b0);
    bus.InstrEnd = 1'b1;             step("pie_ie2",    16'hF302, 1'b1, 1'b1);
    bus.IntEntry = 1'b1; popf(16'hFFFF);
                                     step("int_prio",   16'hF002, 1'b0, 1'b0);
    popf(16'h0FFF);                  step("pre_rst",    16'hFFD7, 1'b1, 1'b0);
    rst_n = 1'b0; popf(16'h0FFF);    step("mid_reset",  16'hF002, 1'b0, 1'b0);
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries want 0", sb.size());
      bad += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
